// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory port between two requesters:
//   port 0 is the multicycle core, port 1 is the loader/debug port.
//   Round-robin arbitration feeds a fixed-latency access FSM
//   (IDLE -> ADDR -> WAIT* -> RESP). Only one access is in flight at a time.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   reqN, weN, adrN,    request, write flag, address and write data of port N;
//   wdN                 the request is held until gntN, and the rest is sampled at gntN
//   gntN                1-cycle combinational grant pulse (IDLE only)
//   doneN, rdN          1-cycle completion pulse; rdN carries read data while doneN=1, else 0
//   busy                high in every state except IDLE
//   mem_adr, mem_wd,    registered memory address / write data / write enable
//   mem_we              (mem_we is high only in the ADDR cycle of a write)
//   mem_rd              memory read data, valid MEM_LAT cycles after the ADDR cycle
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] adr0,
   input  logic [DATA_W-1:0] wd0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] adr1,
   input  logic [DATA_W-1:0] wd1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rd0,
   output logic [DATA_W-1:0] rd1,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam int              CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

   state_t              state_q,   state_d;
   logic                last_q,    last_d;
   logic                owner_q,   owner_d;
   logic                we_q,      we_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [ADDR_W-1:0]   mem_adr_q, mem_adr_d;
   logic [DATA_W-1:0]   mem_wd_q,  mem_wd_d;
   logic                mem_we_q,  mem_we_d;

   // Winner when requests are sampled: a lone requester wins; on a tie the
   // port that was not granted last wins.
   logic win_sel;
   assign win_sel = (req0 && req1) ? ~last_q : req1;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      we_d      = we_q;
      cnt_d     = cnt_q;
      mem_adr_d = mem_adr_q;
      mem_wd_d  = mem_wd_q;
      mem_we_d  = mem_we_q;
      gnt0      = 1'b0;
      gnt1      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               gnt0      = ~win_sel;
               gnt1      = win_sel;
               last_d    = win_sel;
               owner_d   = win_sel;
               we_d      = win_sel ? we1  : we0;
               mem_adr_d = win_sel ? adr1 : adr0;
               mem_wd_d  = win_sel ? wd1  : wd0;
               // Write enable is registered so it lines up with the ADDR cycle.
               mem_we_d  = win_sel ? we1  : we0;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            mem_we_d = 1'b0;
            cnt_d    = CNT_INIT;
            state_d  = (MEM_LAT == 1) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q <= CNT_ONE) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            // Clear the memory-side registers so the port rests at zero in IDLE.
            mem_adr_d = '0;
            mem_wd_d  = '0;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         we_q      <= 1'b0;
         cnt_q     <= '0;
         mem_adr_q <= '0;
         mem_wd_q  <= '0;
         mem_we_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         we_q      <= we_d;
         cnt_q     <= cnt_d;
         mem_adr_q <= mem_adr_d;
         mem_wd_q  <= mem_wd_d;
         mem_we_q  <= mem_we_d;
      end
   end

   // Completion decode: done goes only to the owner, and read data is forced
   // to zero for writes and outside the RESP cycle.
   always_comb begin
      done0 = (state_q == S_RESP) && !owner_q;
      done1 = (state_q == S_RESP) &&  owner_q;
      rd0   = (done0 && !we_q) ? mem_rd : '0;
      rd1   = (done1 && !we_q) ? mem_rd : '0;
   end

   assign busy    = (state_q != S_IDLE);
   assign mem_adr = mem_adr_q;
   assign mem_wd  = mem_wd_q;
   assign mem_we  = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic clk;
   int   total;
   int   bad;

   // Instance 0 runs with MEM_LAT=1, instance 1 with MEM_LAT=3.
   logic        rst    [2];
   logic        req0   [2];
   logic        req1   [2];
   logic        we0    [2];
   logic        we1    [2];
   logic [31:0] adr0   [2];
   logic [31:0] adr1   [2];
   logic [31:0] wd0    [2];
   logic [31:0] wd1    [2];
   logic        gnt0   [2];
   logic        gnt1   [2];
   logic        done0  [2];
   logic        done1  [2];
   logic [31:0] rd0    [2];
   logic [31:0] rd1    [2];
   logic        busy   [2];
   logic [31:0] mem_adr[2];
   logic [31:0] mem_wd [2];
   logic        mem_we [2];
   logic [31:0] mem_rd [2];

   // Memory contents as seen by the arbiter: a fixed function of the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      logic [31:0] h;
      h = (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
      return (a == 32'h10) ? 32'hDEAD_BEEF : h;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter #(
         .ADDR_W (32),
         .DATA_W (32),
         .MEM_LAT((g == 0) ? 1 : 3)
      ) u_dut (
         .clk    (clk),
         .rst    (rst[g]),
         .req0   (req0[g]),
         .we0    (we0[g]),
         .adr0   (adr0[g]),
         .wd0    (wd0[g]),
         .req1   (req1[g]),
         .we1    (we1[g]),
         .adr1   (adr1[g]),
         .wd1    (wd1[g]),
         .gnt0   (gnt0[g]),
         .gnt1   (gnt1[g]),
         .done0  (done0[g]),
         .done1  (done1[g]),
         .rd0    (rd0[g]),
         .rd1    (rd1[g]),
         .busy   (busy[g]),
         .mem_adr(mem_adr[g]),
         .mem_wd (mem_wd[g]),
         .mem_we (mem_we[g]),
         .mem_rd (mem_rd[g])
      );
      assign mem_rd[g] = memf(mem_adr[g]);
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        r0, r1, w0, w1;
      logic [31:0] a0, a1, d0, d1;
      logic        eg0, eg1, ed0, ed1, eb, ewe;
      logic [31:0] erd0, erd1;
      logic        ca;
      logic [31:0] eadr, ewd;
   } vec_t;

   function automatic vec_t mkv(
      input logic r0, input logic r1, input logic w0, input logic w1,
      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
      input logic eg0, input logic eg1, input logic ed0, input logic ed1, input logic eb, input logic ewe,
      input logic [31:0] erd0, input logic [31:0] erd1, input logic ca, input logic [31:0] eadr, input logic [31:0] ewd);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.eg0 = eg0; v.eg1 = eg1; v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.ewe = ewe;
      v.erd0 = erd0; v.erd1 = erd1; v.ca = ca; v.eadr = eadr; v.ewd = ewd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs, sample outputs on the falling edge, then
   // advance to just after the next rising edge.
   task automatic run_cycle(input int g, input string tag, input vec_t v);
      req0[g] = v.r0; req1[g] = v.r1; we0[g] = v.w0; we1[g] = v.w1;
      adr0[g] = v.a0; adr1[g] = v.a1; wd0[g] = v.d0; wd1[g] = v.d1;
      @(negedge clk);
      chk({tag, " gnt0"},  32'(gnt0[g]),  32'(v.eg0));
      chk({tag, " gnt1"},  32'(gnt1[g]),  32'(v.eg1));
      chk({tag, " done0"}, 32'(done0[g]), 32'(v.ed0));
      chk({tag, " done1"}, 32'(done1[g]), 32'(v.ed1));
      chk({tag, " busy"},  32'(busy[g]),  32'(v.eb));
      chk({tag, " mem_we"},32'(mem_we[g]),32'(v.ewe));
      chk({tag, " rd0"},   rd0[g],  v.erd0);
      chk({tag, " rd1"},   rd1[g],  v.erd1);
      if (v.ca)  chk({tag, " mem_adr"}, mem_adr[g], v.eadr);
      if (v.ewe) chk({tag, " mem_wd"},  mem_wd[g],  v.ewd);
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut(input int g);
      rst[g] = 1'b1;
      req0[g] = 1'b0; req1[g] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst[g] = 1'b0;
   endtask

   // Reference model: transactions are scheduled from the grant cycle with
   // plain arithmetic (ADDR at T+1, done at T+1+lat, next grant >= T+2+lat).
   task automatic run_random(input int g, input int lat, input int n);
      int          next_idle;
      int          gc;
      bit          have;
      bit          lst;
      bit          own;
      bit          twe;
      logic [31:0] tadr, twd;
      vec_t        v;
      bit          idle, anyr, win, edone;
      logic [31:0] erd;
      next_idle = 0; gc = -100; have = 0; lst = 1'b1; own = 1'b0; twe = 1'b0;
      tadr = '0; twd = '0;
      reset_dut(g);
      for (int c = 0; c < n; c++) begin
         v.r0 = ($urandom_range(0, 9) < 6);
         v.r1 = ($urandom_range(0, 9) < 6);
         v.w0 = $urandom_range(0, 1) == 1;
         v.w1 = $urandom_range(0, 1) == 1;
         v.a0 = $urandom; v.a1 = $urandom; v.d0 = $urandom; v.d1 = $urandom;
         idle  = (c >= next_idle);
         anyr  = v.r0 || v.r1;
         win   = (v.r0 && v.r1) ? !lst : v.r1;
         edone = have && (c == gc + 1 + lat);
         erd   = (edone && !twe) ? memf(tadr) : 32'h0;
         v.eg0  = idle && anyr && !win;
         v.eg1  = idle && anyr && win;
         v.ed0  = edone && !own;
         v.ed1  = edone && own;
         v.erd0 = v.ed0 ? erd : 32'h0;
         v.erd1 = v.ed1 ? erd : 32'h0;
         v.eb   = !idle;
         v.ewe  = have && (c == gc + 1) && twe;
         v.ewd  = twd;
         v.ca   = have && (c >= gc + 1) && (c <= gc + 1 + lat);
         v.eadr = tadr;
         if (idle && !anyr) begin
            v.ca   = 1'b1;
            v.eadr = 32'h0;
         end
         run_cycle(g, $sformatf("rnd%0d c%0d", g, c), v);
         if (idle && anyr) begin
            have      = 1;
            gc        = c;
            own       = win;
            twe       = win ? v.w1 : v.w0;
            tadr      = win ? v.a1 : v.a0;
            twd       = win ? v.d1 : v.d0;
            lst       = win;
            next_idle = c + 2 + lat;
         end
      end
   endtask

   vec_t tv[18];

   initial begin
      total = 0;
      bad   = 0;
      for (int g = 0; g < 2; g++) begin
         rst[g] = 1'b1; req0[g] = 1'b0; req1[g] = 1'b0; we0[g] = 1'b0; we1[g] = 1'b0;
         adr0[g] = '0; adr1[g] = '0; wd0[g] = '0; wd1[g] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // MEM_LAT=1 table: read, write, alternating ties, dropped request.
      //          r0 r1 w0 w1 a0      a1      d0 d1        g0 g1 d0 d1 bz we rd0                 rd1           ca adr     wd
      tv[0]  = mkv(0, 0, 0, 0, 32'h0,   32'h0,   0, 0,        0, 0, 0, 0, 0, 0, 32'h0,            32'h0,        1, 32'h0,   0);
      tv[1]  = mkv(1, 0, 0, 0, 32'h10,  32'h0,   0, 0,        1, 0, 0, 0, 0, 0, 32'h0,            32'h0,        1, 32'h0,   0);
      tv[2]  = mkv(0, 0, 0, 0, 32'h0,   32'h0,   0, 0,        0, 0, 0, 0, 1, 0, 32'h0,            32'h0,        1, 32'h10,  0);
      tv[3]  = mkv(0, 0, 0, 0, 32'h0,   32'h0,   0, 0,        0, 0, 1, 0, 1, 0, 32'hDEADBEEF,     32'h0,        1, 32'h10,  0);
      tv[4]  = mkv(0, 1, 0, 1, 32'h0,   32'h40,  0, 32'h1234, 0, 1, 0, 0, 0, 0, 32'h0,            32'h0,        0, 32'h0,   0);
      tv[5]  = mkv(0, 0, 0, 0, 32'h0,   32'h0,   0, 0,        0, 0, 0, 0, 1, 1, 32'h0,            32'h0,        1, 32'h40,  32'h1234);
      tv[6]  = mkv(0, 0, 0, 0, 32'h0,   32'h0,   0, 0,        0, 0, 0, 1, 1, 0, 32'h0,            32'h0,        1, 32'h40,  0);
      tv[7]  = mkv(1, 1, 0, 0, 32'h100, 32'h200, 0, 0,        1, 0, 0, 0, 0, 0, 32'h0,            32'h0,        0, 32'h0,   0);
      tv[8]  = mkv(1, 1, 0, 0, 32'h100, 32'h200, 0, 0,        0, 0, 0, 0, 1, 0, 32'h0,            32'h0,        1, 32'h100, 0);
      tv[9]  = mkv(1, 1, 0, 0, 32'h100, 32'h200, 0, 0,        0, 0, 1, 0, 1, 0, memf(32'h100),    32'h0,        1, 32'h100, 0);
      tv[10] = mkv(1, 1, 0, 0, 32'h100, 32'h200, 0, 0,        0, 1, 0, 0, 0, 0, 32'h0,            32'h0,        0, 32'h0,   0);
      tv[11] = mkv(1, 1, 0, 0, 32'h100, 32'h200, 0, 0,        0, 0, 0, 0, 1, 0, 32'h0,            32'h0,        1, 32'h200, 0);
      tv[12] = mkv(1, 1, 0, 0, 32'h100, 32'h200, 0, 0,        0, 0, 0, 1, 1, 0, 32'h0,            memf(32'h200),1, 32'h200, 0);
      tv[13] = mkv(1, 1, 0, 0, 32'h100, 32'h200, 0, 0,        1, 0, 0, 0, 0, 0, 32'h0,            32'h0,        0, 32'h0,   0);
      tv[14] = mkv(0, 1, 0, 0, 32'h0,   32'h300, 0, 0,        0, 0, 0, 0, 1, 0, 32'h0,            32'h0,        1, 32'h100, 0);
      tv[15] = mkv(0, 0, 0, 0, 32'h0,   32'h0,   0, 0,        0, 0, 1, 0, 1, 0, memf(32'h100),    32'h0,        1, 32'h100, 0);
      tv[16] = mkv(0, 0, 0, 0, 32'h0,   32'h0,   0, 0,        0, 0, 0, 0, 0, 0, 32'h0,            32'h0,        1, 32'h0,   0);
      tv[17] = mkv(0, 0, 0, 0, 32'h0,   32'h0,   0, 0,        0, 0, 0, 0, 0, 0, 32'h0,            32'h0,        1, 32'h0,   0);
      for (int i = 0; i < 18; i++) begin
         run_cycle(0, $sformatf("tv%0d", i), tv[i]);
      end

      // MEM_LAT=3: read with WAIT states, request raised mid-access,
      // then reset during WAIT followed by a tie.
      run_cycle(1, "h0",  mkv(1, 0, 0, 0, 32'h20, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,  0));
      run_cycle(1, "h1",  mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 0));
      run_cycle(1, "h2",  mkv(0, 1, 0, 0, 0,      32'h60, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 0));
      run_cycle(1, "h3",  mkv(0, 1, 0, 0, 0,      32'h60, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h20, 0));
      run_cycle(1, "h4",  mkv(0, 1, 0, 0, 0,      32'h60, 0, 0, 0, 0, 1, 0, 1, 0, memf(32'h20), 0, 1, 32'h20, 0));
      run_cycle(1, "h5",  mkv(0, 1, 0, 0, 0,      32'h60, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,  0));
      run_cycle(1, "h6",  mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h60, 0));
      run_cycle(1, "h7",  mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h60, 0));
      run_cycle(1, "h8",  mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h60, 0));
      run_cycle(1, "h9",  mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 1, 1, 0, 0, memf(32'h60), 1, 32'h60, 0));
      run_cycle(1, "h10", mkv(1, 0, 0, 0, 32'h80, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,  0));
      run_cycle(1, "h11", mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h80, 0));
      rst[1] = 1'b1;
      run_cycle(1, "h12", mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h80, 0));
      rst[1] = 1'b0;
      run_cycle(1, "h13", mkv(1, 1, 0, 0, 32'h90, 32'hA0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,  0));
      run_cycle(1, "h14", mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h90, 0));
      run_cycle(1, "h15", mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h90, 0));
      run_cycle(1, "h16", mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h90, 0));
      run_cycle(1, "h17", mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 1, 0, 1, 0, memf(32'h90), 0, 1, 32'h90, 0));
      run_cycle(1, "h18", mkv(0, 0, 0, 0, 0,      0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,  0));

      run_random(0, 1, 400);
      run_random(1, 3, 400);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
